// File: rtl/keylock_param_fsm.sv
// Parametrised combination-lock controller with full-sequence evaluation, fail counting and timed lockout.
// Optional code programming from the unlocked state is enabled by defining KEYLOCK_PROGRAM_EN.
module keylock_param_fsm #(
   parameter int                              DIGIT_W     = 4,
   parameter int                              CODE_LEN    = 6,
   parameter logic [DIGIT_W*CODE_LEN-1:0]     CODE        = {4'd3, 4'd3, 4'd5, 4'd2, 4'd5, 4'd6},
   parameter int                              MAX_FAILS   = 3,
   parameter int                              LOCKOUT_CYC = 16
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               key_valid,
   input  logic [DIGIT_W-1:0]                 key,
   input  logic                               relock,
`ifdef KEYLOCK_PROGRAM_EN
   input  logic                               prog_en,
`endif
   output logic                               locked,
   output logic                               lockout,
   output logic [$clog2(CODE_LEN+1)-1:0]      progress,
   output logic [$clog2(MAX_FAILS+1)-1:0]     fail_cnt
);

   localparam int PW = $clog2(CODE_LEN + 1);
   localparam int FW = $clog2(MAX_FAILS + 1);
   localparam int TW = $clog2(LOCKOUT_CYC + 1);
   localparam int CW = DIGIT_W * CODE_LEN;

   localparam logic [PW-1:0] LAST_DIGIT = PW'(CODE_LEN);
   localparam logic [FW-1:0] FAIL_LIMIT = FW'(MAX_FAILS);
   localparam logic [TW-1:0] TIMER_END  = TW'(LOCKOUT_CYC - 1);

   typedef enum logic [2:0] {
      IDLE,
      ENTRY,
      UNLOCKED,
      LOCKOUT
`ifdef KEYLOCK_PROGRAM_EN
      , PROGRAM
`endif
   } state_t;

   // Digit 0 sits in the most significant slot of the packed code.
   function automatic logic digit_ne(input logic [CW-1:0] c, input logic [PW-1:0] idx,
                                     input logic [DIGIT_W-1:0] k);
      int pos;
      pos = (CODE_LEN - 1 - int'(idx)) * DIGIT_W;
      return c[pos +: DIGIT_W] != k;
   endfunction

   function automatic logic [FW-1:0] fail_sat_inc(input logic [FW-1:0] f);
      return (f >= FAIL_LIMIT) ? f : f + FW'(1);
   endfunction

`ifdef KEYLOCK_PROGRAM_EN
   function automatic logic [CW-1:0] put_digit(input logic [CW-1:0] c, input logic [PW-1:0] idx,
                                               input logic [DIGIT_W-1:0] k);
      logic [CW-1:0] r;
      int            pos;
      r   = c;
      pos = (CODE_LEN - 1 - int'(idx)) * DIGIT_W;
      r[pos +: DIGIT_W] = k;
      return r;
   endfunction
`endif

   state_t        state, state_n;
   logic          locked_n, lockout_n;
   logic [PW-1:0] progress_n, next_prog;
   logic [FW-1:0] fail_n;
   logic          mismatch, mismatch_n, mm;
   logic [TW-1:0] timer, timer_n;
   logic [CW-1:0] code_act;

`ifdef KEYLOCK_PROGRAM_EN
   logic [CW-1:0] code_reg, code_n;
   logic [CW-1:0] prog_buf, prog_buf_n;
   assign code_act = code_reg;
`else
   assign code_act = CODE;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         locked   <= 1'b1;
         lockout  <= 1'b0;
         progress <= '0;
         fail_cnt <= '0;
         mismatch <= 1'b0;
         timer    <= '0;
`ifdef KEYLOCK_PROGRAM_EN
         code_reg <= CODE;
         prog_buf <= CODE;
`endif
      end else begin
         state    <= state_n;
         locked   <= locked_n;
         lockout  <= lockout_n;
         progress <= progress_n;
         fail_cnt <= fail_n;
         mismatch <= mismatch_n;
         timer    <= timer_n;
`ifdef KEYLOCK_PROGRAM_EN
         code_reg <= code_n;
         prog_buf <= prog_buf_n;
`endif
      end
   end

   always_comb begin
      state_n    = state;
      locked_n   = locked;
      lockout_n  = lockout;
      progress_n = progress;
      fail_n     = fail_cnt;
      mismatch_n = mismatch;
      timer_n    = timer;
`ifdef KEYLOCK_PROGRAM_EN
      code_n     = code_reg;
      prog_buf_n = prog_buf;
`endif
      next_prog  = progress + PW'(1);
      mm         = mismatch | digit_ne(code_act, progress, key);

      case (state)
         // IDLE always holds progress=0 and mismatch=0, so it shares the ENTRY path.
         IDLE, ENTRY: begin
            if (relock) begin
               state_n    = IDLE;
               progress_n = '0;
               mismatch_n = 1'b0;
            end else if (key_valid) begin
               if (next_prog == LAST_DIGIT) begin
                  mismatch_n = 1'b0;
                  if (!mm) begin
                     state_n    = UNLOCKED;
                     locked_n   = 1'b0;
                     fail_n     = '0;
                     progress_n = next_prog;
                  end else begin
                     progress_n = '0;
                     fail_n     = fail_sat_inc(fail_cnt);
                     if (fail_n == FAIL_LIMIT) begin
                        state_n   = LOCKOUT;
                        lockout_n = 1'b1;
                        timer_n   = '0;
                     end else begin
                        state_n = IDLE;
                     end
                  end
               end else begin
                  state_n    = ENTRY;
                  progress_n = next_prog;
                  mismatch_n = mm;
               end
            end
         end
         UNLOCKED: begin
            if (relock) begin
               state_n    = IDLE;
               locked_n   = 1'b1;
               progress_n = '0;
`ifdef KEYLOCK_PROGRAM_EN
            end else if (prog_en) begin
               state_n    = PROGRAM;
               progress_n = '0;
               prog_buf_n = code_reg;
`endif
            end
         end
         LOCKOUT: begin
            if (timer == TIMER_END) begin
               state_n    = IDLE;
               lockout_n  = 1'b0;
               fail_n     = '0;
               progress_n = '0;
               timer_n    = '0;
            end else begin
               timer_n = timer + TW'(1);
            end
         end
`ifdef KEYLOCK_PROGRAM_EN
         // New digits collect in prog_buf so an aborted session leaves code_reg intact.
         PROGRAM: begin
            if (relock) begin
               state_n    = IDLE;
               locked_n   = 1'b1;
               progress_n = '0;
            end else if (key_valid) begin
               prog_buf_n = put_digit(prog_buf, progress, key);
               if (next_prog == LAST_DIGIT) begin
                  code_n     = prog_buf_n;
                  state_n    = UNLOCKED;
                  progress_n = '0;
               end else begin
                  progress_n = next_prog;
               end
            end
         end
`endif
         default: begin
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_keylock_param_fsm.sv
// Directed self-checking bench for keylock_param_fsm (default parameters); inputs change and outputs are read on falling edges.
module tb_keylock_param_fsm;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       key_valid = 1'b0;
   logic [3:0] key = 4'd0;
   logic       relock = 1'b0;
`ifdef KEYLOCK_PROGRAM_EN
   logic       prog_en = 1'b0;
`endif
   logic       locked;
   logic       lockout;
   logic [2:0] progress;
   logic [1:0] fail_cnt;

   int total = 0;
   int bad   = 0;

   keylock_param_fsm dut (
      .clk       (clk),
      .reset     (reset),
      .key_valid (key_valid),
      .key       (key),
      .relock    (relock),
`ifdef KEYLOCK_PROGRAM_EN
      .prog_en   (prog_en),
`endif
      .locked    (locked),
      .lockout   (lockout),
      .progress  (progress),
      .fail_cnt  (fail_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input logic [3:0] k);
      key_valid = 1'b1;
      key       = k;
      @(negedge clk);
      key_valid = 1'b0;
      key       = 4'hF;
   endtask

   task automatic enter_code(input logic [23:0] c);
      for (int i = 0; i < 6; i++) press(c[23-4*i -: 4]);
   endtask

   task automatic do_relock();
      relock = 1'b1;
      @(negedge clk);
      relock = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      total++; if (locked !== 1'b1)   begin bad++; $display("FAIL reset_locked got=%0b want=1", locked); end
      total++; if (lockout !== 1'b0)  begin bad++; $display("FAIL reset_lockout got=%0b want=0", lockout); end
      total++; if (progress !== 3'd0) begin bad++; $display("FAIL reset_progress got=%0d want=0", progress); end
      total++; if (fail_cnt !== 2'd0) begin bad++; $display("FAIL reset_fail got=%0d want=0", fail_cnt); end
   endtask

   task automatic test_unlock();
      press(4'd3); press(4'd3); press(4'd5); press(4'd2); press(4'd5);
      total++; if (progress !== 3'd5) begin bad++; $display("FAIL unlock_prog5 got=%0d want=5", progress); end
      total++; if (locked !== 1'b1)   begin bad++; $display("FAIL unlock_early got=%0b want=1", locked); end
      press(4'd6);
      total++; if (locked !== 1'b0)   begin bad++; $display("FAIL unlock_locked got=%0b want=0", locked); end
      total++; if (fail_cnt !== 2'd0) begin bad++; $display("FAIL unlock_fail got=%0d want=0", fail_cnt); end
      do_relock();
      total++; if (locked !== 1'b1)   begin bad++; $display("FAIL relock_locked got=%0b want=1", locked); end
      total++; if (progress !== 3'd0) begin bad++; $display("FAIL relock_progress got=%0d want=0", progress); end
   endtask

   task automatic test_wrong_attempt();
      logic [23:0] c;
      c = 24'h334256;
      for (int i = 0; i < 5; i++) begin
         press(c[23-4*i -: 4]);
         total++; if (progress !== 3'(i + 1)) begin bad++; $display("FAIL wrong_prog%0d got=%0d want=%0d", i, progress, i + 1); end
         total++; if (locked !== 1'b1) begin bad++; $display("FAIL wrong_locked%0d got=%0b want=1", i, locked); end
      end
      press(4'd6);
      total++; if (progress !== 3'd0) begin bad++; $display("FAIL wrong_prog_end got=%0d want=0", progress); end
      total++; if (fail_cnt !== 2'd1) begin bad++; $display("FAIL wrong_fail got=%0d want=1", fail_cnt); end
      total++; if (locked !== 1'b1)   begin bad++; $display("FAIL wrong_locked_end got=%0b want=1", locked); end
   endtask

   task automatic test_lockout();
      int n;
      enter_code(24'h111111);
      total++; if (fail_cnt !== 2'd2) begin bad++; $display("FAIL lo_fail2 got=%0d want=2", fail_cnt); end
      total++; if (lockout !== 1'b0)  begin bad++; $display("FAIL lo_early got=%0b want=0", lockout); end
      enter_code(24'h335255);
      total++; if (lockout !== 1'b1)  begin bad++; $display("FAIL lo_enter got=%0b want=1", lockout); end
      total++; if (fail_cnt !== 2'd3) begin bad++; $display("FAIL lo_fail3 got=%0d want=3", fail_cnt); end
      n = 1;
      enter_code(24'h335256);
      n += 6;
      total++; if (locked !== 1'b1)   begin bad++; $display("FAIL lo_ignore_locked got=%0b want=1", locked); end
      total++; if (progress !== 3'd0) begin bad++; $display("FAIL lo_ignore_prog got=%0d want=0", progress); end
      for (int g = 0; g < 40; g++) begin
         @(negedge clk);
         if (!lockout) break;
         n++;
      end
      total++; if (n !== 16)          begin bad++; $display("FAIL lo_cycles got=%0d want=16", n); end
      total++; if (lockout !== 1'b0)  begin bad++; $display("FAIL lo_exit got=%0b want=0", lockout); end
      total++; if (fail_cnt !== 2'd0) begin bad++; $display("FAIL lo_fail_clr got=%0d want=0", fail_cnt); end
   endtask

   task automatic test_relock_collision();
      enter_code(24'h335256);
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL col_unlock got=%0b want=0", locked); end
      relock    = 1'b1;
      key_valid = 1'b1;
      key       = 4'd3;
      @(negedge clk);
      relock    = 1'b0;
      key_valid = 1'b0;
      total++; if (locked !== 1'b1)   begin bad++; $display("FAIL col_locked got=%0b want=1", locked); end
      total++; if (progress !== 3'd0) begin bad++; $display("FAIL col_progress got=%0d want=0", progress); end
      tick(1);
      total++; if (progress !== 3'd0) begin bad++; $display("FAIL col_discard got=%0d want=0", progress); end
   endtask

   task automatic test_abandon();
      enter_code(24'h335257);
      total++; if (fail_cnt !== 2'd1) begin bad++; $display("FAIL ab_fail1 got=%0d want=1", fail_cnt); end
      press(4'd3); press(4'd4); press(4'd5);
      total++; if (progress !== 3'd3) begin bad++; $display("FAIL ab_prog3 got=%0d want=3", progress); end
      do_relock();
      total++; if (progress !== 3'd0) begin bad++; $display("FAIL ab_prog_clr got=%0d want=0", progress); end
      total++; if (fail_cnt !== 2'd1) begin bad++; $display("FAIL ab_fail_keep got=%0d want=1", fail_cnt); end
      enter_code(24'h335256);
      total++; if (locked !== 1'b0)   begin bad++; $display("FAIL ab_unlock got=%0b want=0", locked); end
      total++; if (fail_cnt !== 2'd0) begin bad++; $display("FAIL ab_fail_clr got=%0d want=0", fail_cnt); end
      do_relock();
      press(4'd3); press(4'd3);
      total++; if (progress !== 3'd2) begin bad++; $display("FAIL ab_prog2 got=%0d want=2", progress); end
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      total++; if (progress !== 3'd0) begin bad++; $display("FAIL ab_rst_prog got=%0d want=0", progress); end
      total++; if (locked !== 1'b1)   begin bad++; $display("FAIL ab_rst_locked got=%0b want=1", locked); end
   endtask

`ifdef KEYLOCK_PROGRAM_EN
   task automatic test_program();
      enter_code(24'h335256);
      prog_en = 1'b1;
      tick(1);
      prog_en = 1'b0;
      enter_code(24'h123456);
      total++; if (locked !== 1'b0)   begin bad++; $display("FAIL pg_still_open got=%0b want=0", locked); end
      do_relock();
      enter_code(24'h335256);
      total++; if (locked !== 1'b1)   begin bad++; $display("FAIL pg_old_locked got=%0b want=1", locked); end
      total++; if (fail_cnt !== 2'd1) begin bad++; $display("FAIL pg_old_fail got=%0d want=1", fail_cnt); end
      enter_code(24'h123456);
      total++; if (locked !== 1'b0)   begin bad++; $display("FAIL pg_new_unlock got=%0b want=0", locked); end
      total++; if (fail_cnt !== 2'd0) begin bad++; $display("FAIL pg_new_fail got=%0d want=0", fail_cnt); end
   endtask
`endif

   initial begin
      @(negedge clk);
      test_reset();
      test_unlock();
      test_wrong_attempt();
      test_lockout();
      test_relock_collision();
      test_abandon();
`ifdef KEYLOCK_PROGRAM_EN
      test_program();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
